// File: rtl/word_narrow_pkg.sv
// Shared encodings and helpers for the 32->16 word narrowing block.
package word_narrow_pkg;

  localparam int unsigned IN_W_DEF  = 32;
  localparam int unsigned OUT_W_DEF = 16;

  localparam logic [1:0] MODE_SSAT  = 2'b00;
  localparam logic [1:0] MODE_USAT  = 2'b01;
  localparam logic [1:0] MODE_SPLIT = 2'b10;
  localparam logic [1:0] MODE_TRUNC = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BEAT    = 2'd1;
  localparam logic [1:0] ST_HI_PEND = 2'd2;

  localparam logic [OUT_W_DEF-1:0] SAT_POS  = 16'h7FFF;
  localparam logic [OUT_W_DEF-1:0] SAT_NEG  = 16'h8000;
  localparam logic [OUT_W_DEF-1:0] USAT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [OUT_W_DEF-1:0] data;
    logic                 ovf;
  } sat_res_t;

  // True when the word equals the sign extension of its low half.
  function automatic logic fits_s16(input logic [IN_W_DEF-1:0] x);
    return x[IN_W_DEF-1:OUT_W_DEF-1] == {(IN_W_DEF-OUT_W_DEF+1){x[IN_W_DEF-1]}};
  endfunction

endpackage

// File: rtl/word_narrow_sat.sv
// Combinational single-beat narrowing: signed/unsigned saturation and truncation.
module narrow_sat
  import word_narrow_pkg::*;
(
  input  logic [IN_W_DEF-1:0]  word,
  input  logic [1:0]           mode,
  output logic [OUT_W_DEF-1:0] data_c,
  output logic                 ovf_c
);

  sat_res_t res;
  logic     fits;

  assign fits = fits_s16(word);

  always_comb begin
    res = '{data: word[OUT_W_DEF-1:0], ovf: 1'b0};
    case (mode)
      MODE_SSAT: begin
        if (!fits) res = '{data: (word[IN_W_DEF-1] ? SAT_NEG : SAT_POS), ovf: 1'b1};
      end
      MODE_USAT: begin
        if (word[IN_W_DEF-1:OUT_W_DEF] != '0) res = '{data: USAT_MAX, ovf: 1'b1};
      end
      MODE_TRUNC: res.ovf = !fits;
      default: ;
    endcase
  end

  assign data_c = res.data;
  assign ovf_c  = res.ovf;

endmodule

// File: rtl/word_narrow.sv
// Narrows 32-bit words onto a 16-bit valid/ready stream (saturate, truncate or split).
module word_narrow
  import word_narrow_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_word,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_ovf
);

  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [OUT_W-1:0] hi_q, hi_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;
  logic [OUT_W-1:0] sat_data_c;
  logic             sat_ovf_c;
  logic             accept;
  logic             out_xfer;

  narrow_sat u_sat (
    .word   (in_word),
    .mode   (in_mode),
    .data_c (sat_data_c),
    .ovf_c  (sat_ovf_c)
  );

  // Combinational path from out_ready: a final beat leaving frees the stage this cycle.
  assign in_ready = !valid_q || (out_ready && last_q);
  assign accept   = in_valid && in_ready;
  assign out_xfer = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    hi_d    = hi_q;
    valid_d = valid_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_HI_PEND: begin
        if (out_xfer) begin
          state_d = ST_BEAT;
          data_d  = hi_q;
          last_d  = 1'b1;
          ovf_d   = 1'b0;
        end
      end
      ST_IDLE, ST_BEAT: begin
        if (accept) begin
          valid_d = 1'b1;
          if (in_mode == MODE_SPLIT) begin
            state_d = ST_HI_PEND;
            data_d  = in_word[OUT_W-1:0];
            hi_d    = in_word[IN_W-1:OUT_W];
            last_d  = 1'b0;
            ovf_d   = 1'b0;
          end else begin
            state_d = ST_BEAT;
            data_d  = sat_data_c;
            last_d  = 1'b1;
            ovf_d   = sat_ovf_c;
          end
        end else if (out_xfer) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      hi_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      hi_q    <= hi_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_ovf   = ovf_q;

endmodule
